// File: rtl/id_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : id_pkg                                                       |
// | Description : Shared widths and latency constants for the ID-stage operand |
// |               hazard unit (scoreboard, forward mux, instruction hold).     |
// | Contents    : XLEN, NREG, AW, NSRC, NFWD, CNT_W, INST_W, issue latencies,  |
// |               major opcodes that select a non-ALU latency.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package id_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int AW     = $clog2(NREG);
   localparam int NSRC   = 2;
   localparam int NFWD   = 3;
   localparam int CNT_W  = 2;
   localparam int INST_W = 32;

   // Cycles from issue until a result can be picked up by forwarding.
   localparam logic [CNT_W-1:0] LAT_ALU  = 2'd0;
   localparam logic [CNT_W-1:0] LAT_LOAD = 2'd1;

   // Major opcodes of the load instructions that issue with LAT_LOAD.
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   // Issue latency implied by a major opcode.
   function automatic logic [CNT_W-1:0] lat_of_opcode(input logic [5:0] op);
      logic [CNT_W-1:0] lat;
      lat = LAT_ALU;
      if (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU)
         lat = LAT_LOAD;
      return lat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_inst_hold.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_inst_hold                                                 |
// | Description : Keeps the instruction seen by the decoder stable while ID is |
// |               stalled; the inst SRAM output may move on underneath it.     |
// | Ports       : clk, rst      clock / synchronous active-high reset          |
// |               flush         drop any held instruction                      |
// |               id_stall      ID stalled this cycle                          |
// |               inst_in       instruction from inst SRAM                     |
// |               inst_out      instruction presented to decoder               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module id_inst_hold
   import id_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_stall,
   input  logic [INST_W-1:0] inst_in,
   output logic [INST_W-1:0] inst_out
);

   logic              hold_vld;
   logic [INST_W-1:0] hold_inst;

   // Capturing inst_out (not inst_in) keeps the first captured word for the
   // whole length of a multi-cycle stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld  <= 1'b0;
         hold_inst <= '0;
      end else if (flush) begin
         hold_vld  <= 1'b0;
      end else begin
         hold_vld <= id_stall;
         if (id_stall)
            hold_inst <= inst_out;
      end
   end

   assign inst_out = hold_vld ? hold_inst : inst_in;

endmodule
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_hazard_scoreboard                                         |
// | Description : ID-stage operand hazard unit. Per-register latency counters  |
// |               raise stall_req on RAW hazards forwarding cannot cover; the  |
// |               forward mux picks the youngest matching EX/MEM/WB source     |
// |               over regfile data; HI/LO busy tracks the divider.            |
// | Ports       : clk, rst, flush, pipe_hold, id_stall   control               |
// |               inst_in / inst_out                     instruction hold      |
// |               src_addr, src_use, rf_rdata, src_data  operand read ports    |
// |               fwd_we, fwd_addr, fwd_data             forward sources       |
// |               issue_valid/we/waddr/lat               EX issue record       |
// |               hilo_read, div_start, div_done, hilo_busy  HI/LO tracking    |
// |               stall_req                              hazard stall request  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module id_hazard_scoreboard
   import id_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int NSRC  = 2,
   parameter int NFWD  = 3,
   parameter int CNT_W = 2,
   localparam int RAW  = $clog2(NREG)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 pipe_hold,
   input  logic                 id_stall,
   input  logic [INST_W-1:0]    inst_in,
   output logic [INST_W-1:0]    inst_out,
   input  logic [NSRC*RAW-1:0]  src_addr,
   input  logic [NSRC-1:0]      src_use,
   input  logic [NSRC*XLEN-1:0] rf_rdata,
   input  logic [NFWD-1:0]      fwd_we,
   input  logic [NFWD*RAW-1:0]  fwd_addr,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   output logic [NSRC*XLEN-1:0] src_data,
   input  logic                 issue_valid,
   input  logic                 issue_we,
   input  logic [RAW-1:0]       issue_waddr,
   input  logic [CNT_W-1:0]     issue_lat,
   input  logic                 hilo_read,
   input  logic                 div_start,
   input  logic                 div_done,
   output logic                 hilo_busy,
   output logic                 stall_req
);

   logic [CNT_W-1:0] cnt [NREG];
   logic [NSRC-1:0]  src_hz;
   logic             issue_rec;

   assign issue_rec = issue_valid && issue_we && (issue_waddr != '0);

   // ---------------- per-register pending-latency counters ----------------
   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      if (r == 0) begin : g_zero
         assign cnt[r] = '0;            // $0 is never pending
      end else begin : g_reg
         logic [CNT_W-1:0] c;
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               c <= '0;                 // flush also discards a same-cycle issue
            end else if (issue_rec && issue_waddr == RAW'(r)) begin
               c <= issue_lat;          // newest write wins, even under pipe_hold
            end else if (!pipe_hold && c != '0) begin
               c <= c - 1'b1;
            end
         end
         assign cnt[r] = c;
      end
   end

   // ---------------- hazard detect and forward mux per source ----------------
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      logic [RAW-1:0]  a;
      logic [XLEN-1:0] d;

      assign a         = src_addr[i*RAW +: RAW];
      assign src_hz[i] = src_use[i] && (a != '0) && (cnt[a] != '0);

      // Walk oldest to youngest so the lowest-index (youngest) match wins.
      always_comb begin
         d = rf_rdata[i*XLEN +: XLEN];
         for (int j = NFWD - 1; j >= 0; j--) begin
            if (fwd_we[j] && fwd_addr[j*RAW +: RAW] == a)
               d = fwd_data[j*XLEN +: XLEN];
         end
         if (a == '0)
            d = '0;
      end

      assign src_data[i*XLEN +: XLEN] = d;
   end

   // ---------------- HI/LO divider busy ----------------
   // A new start beats a same-cycle done; flush leaves the divider running.
   always_ff @(posedge clk) begin
      if (rst)
         hilo_busy <= 1'b0;
      else if (div_start)
         hilo_busy <= 1'b1;
      else if (div_done)
         hilo_busy <= 1'b0;
   end

   assign stall_req = (|src_hz) || (hilo_read && hilo_busy);

   // ---------------- instruction hold ----------------
   id_inst_hold u_inst_hold (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .id_stall (id_stall),
      .inst_in  (inst_in),
      .inst_out (inst_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_id_hazard_scoreboard                                      |
// | Description : Directed self-checking bench for id_hazard_scoreboard.       |
// |               Inputs change 2 ns after the rising edge, outputs are        |
// |               sampled 1 ns later.                                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_id_hazard_scoreboard;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NSRC = 2;
   localparam int NFWD = 3;
   localparam int CW   = 2;

   logic                 clk = 1'b0;
   logic                 rst, flush, pipe_hold, id_stall;
   logic [31:0]          inst_in, inst_out;
   logic [NSRC*AW-1:0]   src_addr;
   logic [NSRC-1:0]      src_use;
   logic [NSRC*XLEN-1:0] rf_rdata;
   logic [NFWD-1:0]      fwd_we;
   logic [NFWD*AW-1:0]   fwd_addr;
   logic [NFWD*XLEN-1:0] fwd_data;
   logic [NSRC*XLEN-1:0] src_data;
   logic                 issue_valid, issue_we;
   logic [AW-1:0]        issue_waddr;
   logic [CW-1:0]        issue_lat;
   logic                 hilo_read, div_start, div_done, hilo_busy, stall_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_hazard_scoreboard #(
      .XLEN(XLEN), .NREG(32), .NSRC(NSRC), .NFWD(NFWD), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .pipe_hold(pipe_hold), .id_stall(id_stall),
      .inst_in(inst_in), .inst_out(inst_out),
      .src_addr(src_addr), .src_use(src_use), .rf_rdata(rf_rdata),
      .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .src_data(src_data),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_waddr(issue_waddr),
      .issue_lat(issue_lat), .hilo_read(hilo_read), .div_start(div_start),
      .div_done(div_done), .hilo_busy(hilo_busy), .stall_req(stall_req)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [AW-1:0] wa, input logic [CW-1:0] lat);
      issue_valid = 1'b1; issue_we = 1'b1; issue_waddr = wa; issue_lat = lat;
   endtask

   task automatic no_issue();
      issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0; issue_lat = '0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; pipe_hold = 1'b0; id_stall = 1'b0;
      inst_in = 32'hDEAD0001; src_addr = '0; src_use = '0; rf_rdata = '0;
      fwd_we = '0; fwd_addr = '0; fwd_data = '0;
      no_issue();
      hilo_read = 1'b0; div_start = 1'b0; div_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      settle();

      // Reset state
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      check("rst_hilo", {31'd0, hilo_busy}, 32'd0);
      check("rst_inst", inst_out, 32'hDEAD0001);

      // lw $5 (lat 1), dependent read stalls exactly one cycle, then MEM forward
      issue(5'd5, 2'd1);
      tick();
      no_issue();
      src_addr[0 +: AW] = 5'd5; src_use = 2'b01;
      settle();
      check("lw_stall", {31'd0, stall_req}, 32'd1);
      tick();
      fwd_we = 3'b010; fwd_addr[AW +: AW] = 5'd5; fwd_data[XLEN +: XLEN] = 32'hCAFE0005;
      rf_rdata[0 +: XLEN] = 32'h11111111;
      settle();
      check("lw_release", {31'd0, stall_req}, 32'd0);
      check("lw_fwd_mem", src_data[0 +: XLEN], 32'hCAFE0005);

      // addu $3 (lat 0), EX forward, no stall
      issue(5'd3, 2'd0);
      tick();
      no_issue();
      src_use = 2'b10; src_addr[AW +: AW] = 5'd3;
      fwd_we = 3'b001; fwd_addr[0 +: AW] = 5'd3; fwd_data[0 +: XLEN] = 32'h00001234;
      settle();
      check("alu_nostall", {31'd0, stall_req}, 32'd0);
      check("alu_fwd_ex", src_data[XLEN +: XLEN], 32'h00001234);

      // EX and WB both write $7: youngest wins; $0 reads zero despite a match
      fwd_we = 3'b111;
      fwd_addr = {5'd7, 5'd0, 5'd7};
      fwd_data = {32'h0000BBBB, 32'h00005555, 32'h0000AAAA};
      src_addr = {5'd0, 5'd7}; src_use = 2'b11;
      rf_rdata = {32'h99999999, 32'h88888888};
      settle();
      check("fwd_youngest", src_data[0 +: XLEN], 32'h0000AAAA);
      check("fwd_r0_zero", src_data[XLEN +: XLEN], 32'h00000000);
      src_addr[AW +: AW] = 5'd9;
      settle();
      check("rf_fallback", src_data[XLEN +: XLEN], 32'h99999999);
      fwd_we = '0; src_use = '0; src_addr = '0;

      // Divider: mfhi stalls until div_done
      div_start = 1'b1;
      tick();
      div_start = 1'b0; hilo_read = 1'b1;
      settle();
      check("div_busy", {31'd0, hilo_busy}, 32'd1);
      check("mfhi_stall", {31'd0, stall_req}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      check("flush_keeps_hilo", {31'd0, stall_req}, 32'd1);
      div_done = 1'b1;
      tick();
      div_done = 1'b0;
      settle();
      check("div_done_clr", {31'd0, hilo_busy}, 32'd0);
      check("mfhi_release", {31'd0, stall_req}, 32'd0);
      div_start = 1'b1; div_done = 1'b1;
      tick();
      div_start = 1'b0; div_done = 1'b0;
      settle();
      check("start_done_same", {31'd0, hilo_busy}, 32'd1);
      div_done = 1'b1;
      tick();
      div_done = 1'b0; hilo_read = 1'b0;
      settle();
      check("div_done_2", {31'd0, hilo_busy}, 32'd0);

      // Instruction hold over a 3-cycle stall
      inst_in = 32'hA0000001; id_stall = 1'b1;
      tick();
      inst_in = 32'hB0000002;
      settle();
      check("hold_c1", inst_out, 32'hA0000001);
      tick();
      inst_in = 32'hB0000003;
      settle();
      check("hold_c2", inst_out, 32'hA0000001);
      tick();
      id_stall = 1'b0; inst_in = 32'hC0000004;
      settle();
      check("hold_c3", inst_out, 32'hA0000001);
      tick();
      settle();
      check("hold_release", inst_out, 32'hC0000004);

      // lw $5 issued under pipe_hold: stall persists while frozen, flush clears
      pipe_hold = 1'b1;
      issue(5'd5, 2'd1);
      tick();
      no_issue();
      src_addr[0 +: AW] = 5'd5; src_use = 2'b01;
      settle();
      check("hold_issue_rec", {31'd0, stall_req}, 32'd1);
      tick();
      settle();
      check("pipe_hold_1", {31'd0, stall_req}, 32'd1);
      tick();
      settle();
      check("pipe_hold_2", {31'd0, stall_req}, 32'd1);
      pipe_hold = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      check("flush_clr", {31'd0, stall_req}, 32'd0);

      // Latency 3 counts down over three stall cycles
      src_addr[0 +: AW] = 5'd4;
      issue(5'd4, 2'd3);
      tick();
      no_issue();
      settle();
      check("lat3_c1", {31'd0, stall_req}, 32'd1);
      tick();
      settle();
      check("lat3_c2", {31'd0, stall_req}, 32'd1);
      tick();
      settle();
      check("lat3_c3", {31'd0, stall_req}, 32'd1);
      tick();
      settle();
      check("lat3_done", {31'd0, stall_req}, 32'd0);

      // WAW: newer lat-0 write overrides pending lat-3
      issue(5'd4, 2'd3);
      tick();
      issue(5'd4, 2'd0);
      tick();
      no_issue();
      settle();
      check("waw_newest", {31'd0, stall_req}, 32'd0);

      // Unused source does not stall
      issue(5'd4, 2'd3);
      tick();
      no_issue();
      src_use = 2'b00;
      settle();
      check("src_unused", {31'd0, stall_req}, 32'd0);
      src_use = 2'b01;
      settle();
      check("src_used", {31'd0, stall_req}, 32'd1);

      // Flush with simultaneous issue discards the issue
      issue(5'd6, 2'd3); flush = 1'b1;
      tick();
      no_issue(); flush = 1'b0;
      src_addr[0 +: AW] = 5'd6;
      settle();
      check("flush_drop_issue", {31'd0, stall_req}, 32'd0);

      // Writes to $0 are never recorded
      issue(5'd0, 2'd3);
      tick();
      no_issue();
      src_addr[0 +: AW] = 5'd0;
      settle();
      check("r0_never_pending", {31'd0, stall_req}, 32'd0);

      // Reset mid-operation forgets pending writes and the divider
      issue(5'd4, 2'd3); div_start = 1'b1;
      tick();
      no_issue(); div_start = 1'b0;
      src_addr[0 +: AW] = 5'd4;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("rst_mid_stall", {31'd0, stall_req}, 32'd0);
      check("rst_mid_hilo", {31'd0, hilo_busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
